// File: rtl/seq_adder_display.sv
// seq_adder_display
//   Holds two WIDTH-bit operands written from the lcd_module touch input.
//   On a start pulse, it computes A + B + cin as a chunked ripple add.
//   The add takes CHUNK bits per cycle over NCHUNK = WIDTH/CHUNK cycles.
//   A busy/done handshake brackets the calculation.
//   The block also serves its lcd_module display slots.
//
// Parameters
//   WIDTH      operand/result width (1..32, multiple of CHUNK)
//   CHUNK      bits added per calculation cycle
//   DISP_BASE  first display_number slot owned by this block
//
// Ports
//   clk, resetn            clock; synchronous active-low reset
//   input_sel              0: input_value -> A, 1: input_value -> B
//   sw_cin                 carry-in, sampled with start
//   start                  single-cycle compute request (ignored unless idle)
//   input_valid            operand write strobe
//   input_value[31:0]      operand data (low WIDTH bits used)
//   display_number[5:0]    slot requested by lcd_module
//   display_valid          slot belongs to this block (registered)
//   display_name[39:0]     5-char ASCII label (registered)
//   display_value[31:0]    slot value, zero-extended (registered)
//   busy                   high while calculating
//   done                   one-cycle pulse when result/led_cout update
//   result[WIDTH-1:0]      last completed sum
//   led_cout               last completed carry-out
//
// Build option
//   SEQ_ADDER_STATS_EN  adds a 32-bit completed-operation counter.
//                       The counter is shown on slot DISP_BASE+3 as "COUNT".

module seq_adder_display #(
  parameter int WIDTH     = 32,
  parameter int CHUNK     = 8,
  parameter int DISP_BASE = 42
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             input_sel,
  input  logic             sw_cin,
  input  logic             start,
  input  logic             input_valid,
  input  logic [31:0]      input_value,
  input  logic [5:0]       display_number,
  output logic             display_valid,
  output logic [39:0]      display_name,
  output logic [31:0]      display_value,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             led_cout
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-1:0] a_q, b_q, work, work_next;
  logic             carry;
  logic [IDXW-1:0]  idx;
  logic [CHUNK:0]   chunk_sum;
  logic             last_chunk;

  assign last_chunk = (idx == IDXW'(NCHUNK - 1));

  // FSM state register
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = CALC;
      CALC: begin
        busy = 1'b1;
        if (last_chunk) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // One chunk of the ripple add.
  // work_next is the working sum with the current chunk filled in.
  // On the last chunk, work_next is the complete result.
  always_comb begin
    chunk_sum = {1'b0, a_q[idx*CHUNK +: CHUNK]}
              + {1'b0, b_q[idx*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, carry};
    work_next = work;
    work_next[idx*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
  end

  // Operands, snapshot and datapath.
  // The snapshot decouples the calculation from later operand writes.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      a_reg    <= '0;
      b_reg    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      work     <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      result   <= '0;
      led_cout <= 1'b0;
    end else begin
      if (input_valid) begin
        if (input_sel) b_reg <= input_value[WIDTH-1:0];
        else           a_reg <= input_value[WIDTH-1:0];
      end
      if (state == IDLE && start) begin
        a_q   <= a_reg;
        b_q   <= b_reg;
        carry <= sw_cin;
        idx   <= '0;
        work  <= '0;
      end
      if (state == CALC) begin
        work  <= work_next;
        carry <= chunk_sum[CHUNK];
        idx   <= idx + 1'b1;
        if (last_chunk) begin
          result   <= work_next;
          led_cout <= chunk_sum[CHUNK];
        end
      end
    end
  end

`ifdef SEQ_ADDER_STATS_EN
  logic [31:0] op_count;

  always_ff @(posedge clk) begin
    if (!resetn)            op_count <= '0;
    else if (state == DONE) op_count <= op_count + 32'd1;
  end
`endif

  // Display slots, registered: one cycle from display_number to output.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      display_valid <= 1'b0;
      display_name  <= '0;
      display_value <= '0;
    end else begin
      display_valid <= 1'b0;
      display_name  <= '0;
      display_value <= '0;
      if (display_number == 6'(DISP_BASE)) begin
        display_valid <= 1'b1;
        display_name  <= "ADD_1";
        display_value <= 32'(a_reg);
      end else if (display_number == 6'(DISP_BASE + 1)) begin
        display_valid <= 1'b1;
        display_name  <= "ADD_2";
        display_value <= 32'(b_reg);
      end else if (display_number == 6'(DISP_BASE + 2)) begin
        display_valid <= 1'b1;
        display_name  <= "RESUL";
        display_value <= 32'(result);
      end
`ifdef SEQ_ADDER_STATS_EN
      else if (display_number == 6'(DISP_BASE + 3)) begin
        display_valid <= 1'b1;
        display_name  <= "COUNT";
        display_value <= op_count;
      end
`endif
    end
  end

endmodule

// File: tb/tb_seq_adder_display.sv
// Self-checking bench for seq_adder_display (WIDTH=32, CHUNK=8, DISP_BASE=42).
// Each sum expectation is queued when start is driven.
// It is popped and compared when done appears.
module tb_seq_adder_display;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        input_sel = 1'b0;
  logic        sw_cin = 1'b0;
  logic        start = 1'b0;
  logic        input_valid = 1'b0;
  logic [31:0] input_value = '0;
  logic [5:0]  display_number = '0;
  logic        display_valid;
  logic [39:0] display_name;
  logic [31:0] display_value;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        led_cout;

  int          errors = 0;
  int          checks = 0;

  logic [31:0] model_a = '0;
  logic [31:0] model_b = '0;
  logic [31:0] model_result = '0;
  logic        model_cout = 1'b0;
  logic [31:0] model_count = '0;
  logic [32:0] exp_q[$];

  always #50 clk = ~clk;

  seq_adder_display #(.WIDTH(32), .CHUNK(8), .DISP_BASE(42)) dut (
    .clk(clk), .resetn(resetn), .input_sel(input_sel), .sw_cin(sw_cin),
    .start(start), .input_valid(input_valid), .input_value(input_value),
    .display_number(display_number), .display_valid(display_valid),
    .display_name(display_name), .display_value(display_value),
    .busy(busy), .done(done), .result(result), .led_cout(led_cout)
  );

  task automatic write_op(input logic sel, input logic [31:0] v);
    @(negedge clk);
    input_sel = sel; input_value = v; input_valid = 1'b1;
    if (sel) model_b = v; else model_a = v;
    @(negedge clk);
    input_valid = 1'b0;
  endtask

  // Caller guarantees the DUT is idle, so this start is accepted.
  task automatic pulse_start(input logic ci);
    @(negedge clk);
    sw_cin = ci; start = 1'b1;
    exp_q.push_back(33'(model_a) + 33'(model_b) + 33'(ci));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Bounded wait for done.
  // Returns the busy-cycle count.
  // Also reports whether result held its value while waiting.
  task automatic wait_done(output int nbusy, output bit seen, output bit held);
    logic [31:0] r0;
    r0 = result; nbusy = 0; seen = 1'b0; held = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (done) begin seen = 1'b1; break; end
      if (busy) nbusy++;
      if (result !== r0) held = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
    checks++; if (led_cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b expected 0", led_cout); end
    checks++; if (display_valid !== 1'b0) begin errors++; $display("FAIL reset_dvalid: got %b expected 0", display_valid); end
    resetn = 1'b1;
    model_a = '0; model_b = '0; model_result = '0; model_cout = 1'b0; model_count = '0;
    exp_q.delete();
  endtask

  // Pops the scoreboard and checks a completed operation at the done cycle.
  task automatic test_op(input string name, input logic [31:0] a, input logic [31:0] b, input logic ci);
    int nb; bit seen, held; logic [32:0] exp;
    write_op(1'b0, a); write_op(1'b1, b);
    pulse_start(ci);
    wait_done(nb, seen, held);
    exp = exp_q.pop_front();
    checks++; if (!seen) begin errors++; $display("FAIL %s_done: done not seen within 20 cycles", name); end
    checks++; if (nb != 4) begin errors++; $display("FAIL %s_busy_cycles: got %0d expected 4", name, nb); end
    checks++; if (!held) begin errors++; $display("FAIL %s_result_held: result changed during CALC", name); end
    checks++; if (result !== exp[31:0]) begin errors++; $display("FAIL %s_result: got %h expected %h", name, result, exp[31:0]); end
    checks++; if (led_cout !== exp[32]) begin errors++; $display("FAIL %s_cout: got %b expected %b", name, led_cout, exp[32]); end
    if (seen) model_count++;
    model_result = exp[31:0]; model_cout = exp[32];
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s_done_pulse: done still %b one cycle later", name, done); end
  endtask

  task automatic test_basic;
    test_op("basic", 32'h0000_00FF, 32'h0000_0001, 1'b0);
  endtask

  task automatic test_display;
    display_number = 6'd44; @(negedge clk);
    checks++; if (display_valid !== 1'b1 || display_name !== "RESUL" || display_value !== model_result) begin
      errors++; $display("FAIL disp_44: got v=%b n=%h val=%h expected v=1 RESUL val=%h", display_valid, display_name, display_value, model_result); end
    display_number = 6'd43; @(negedge clk);
    checks++; if (display_valid !== 1'b1 || display_name !== "ADD_2" || display_value !== model_b) begin
      errors++; $display("FAIL disp_43: got v=%b n=%h val=%h expected v=1 ADD_2 val=%h", display_valid, display_name, display_value, model_b); end
    display_number = 6'd42; @(negedge clk);
    checks++; if (display_valid !== 1'b1 || display_name !== "ADD_1" || display_value !== model_a) begin
      errors++; $display("FAIL disp_42: got v=%b n=%h val=%h expected v=1 ADD_1 val=%h", display_valid, display_name, display_value, model_a); end
    display_number = 6'd50; @(negedge clk);
    checks++; if (display_valid !== 1'b0 || display_name !== 40'h0 || display_value !== 32'h0) begin
      errors++; $display("FAIL disp_50: got v=%b n=%h val=%h expected all 0", display_valid, display_name, display_value); end
    display_number = 6'd41; @(negedge clk);
    checks++; if (display_valid !== 1'b0) begin errors++; $display("FAIL disp_41: got v=%b expected 0", display_valid); end
    display_number = 6'd0;
  endtask

  task automatic test_carry_chain;
    test_op("carry", 32'hFFFF_FFFF, 32'h0, 1'b1);
  endtask

  task automatic test_start_while_busy;
    int nb, extra; bit seen, held; logic [32:0] exp;
    write_op(1'b0, 32'h1); write_op(1'b1, 32'h2);
    pulse_start(1'b0);
    // Already in CALC: write A and retry start together.
    input_sel = 1'b0; input_value = 32'h10; input_valid = 1'b1; start = 1'b1;
    model_a = 32'h10;
    @(negedge clk);
    input_valid = 1'b0; start = 1'b0;
    wait_done(nb, seen, held);
    exp = exp_q.pop_front();
    checks++; if (!seen) begin errors++; $display("FAIL busy_start_done: done not seen"); end
    checks++; if (result !== exp[31:0]) begin errors++; $display("FAIL busy_start_result: got %h expected %h", result, exp[31:0]); end
    if (seen) model_count++;
    model_result = exp[31:0]; model_cout = exp[32];
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL busy_start_ignored: got %0d extra busy/done cycles expected 0", extra); end
    display_number = 6'd42; @(negedge clk);
    checks++; if (display_value !== 32'h10) begin errors++; $display("FAIL busy_start_a: got %h expected 00000010", display_value); end
    display_number = 6'd0;
  endtask

  task automatic test_reset_midcalc;
    int seen_done;
    write_op(1'b0, 32'h5); write_op(1'b1, 32'h7);
    pulse_start(1'b0);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    exp_q.delete();
    model_a = '0; model_b = '0; model_result = '0; model_cout = 1'b0; model_count = '0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    checks++; if (result !== 32'h0 || led_cout !== 1'b0) begin errors++; $display("FAIL midreset_result: got %h/%b expected 0/0", result, led_cout); end
    seen_done = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) seen_done++;
      @(negedge clk);
    end
    checks++; if (seen_done != 0) begin errors++; $display("FAIL midreset_no_done: got %0d done cycles expected 0", seen_done); end
    test_op("after_reset", 32'h0000_1234, 32'h0000_4321, 1'b1);
  endtask

  task automatic test_count;
    test_op("count1", 32'h8000_0000, 32'h8000_0000, 1'b0);
    test_op("count2", 32'h00FF_FF00, 32'h0000_0100, 1'b1);
    display_number = 6'd45; @(negedge clk);
`ifdef SEQ_ADDER_STATS_EN
    checks++; if (display_valid !== 1'b1 || display_name !== "COUNT" || display_value !== model_count) begin
      errors++; $display("FAIL disp_count: got v=%b n=%h val=%0d expected v=1 COUNT val=%0d", display_valid, display_name, display_value, model_count); end
`else
    checks++; if (display_valid !== 1'b0 || display_value !== 32'h0) begin
      errors++; $display("FAIL disp_count: got v=%b val=%h expected v=0 val=0 (stats disabled)", display_valid, display_value); end
`endif
    display_number = 6'd0;
  endtask

  task automatic test_back_to_back;
    int nb; bit seen, held; logic [32:0] exp;
    write_op(1'b0, 32'h1111_1111); write_op(1'b1, 32'h2222_2222);
    pulse_start(1'b0);
    wait_done(nb, seen, held);
    exp = exp_q.pop_front();
    checks++; if (result !== exp[31:0]) begin errors++; $display("FAIL b2b_result: got %h expected %h", result, exp[31:0]); end
    // Start held high during the done cycle must be dropped.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_start_in_done: got busy=%b expected 0", busy); end
    // Start with a same-cycle write to B: the snapshot uses the old B.
    input_sel = 1'b1; input_value = 32'hF000_0000; input_valid = 1'b1; start = 1'b1; sw_cin = 1'b1;
    exp_q.push_back(33'(model_a) + 33'(model_b) + 33'd1);
    model_b = 32'hF000_0000;
    @(negedge clk);
    input_valid = 1'b0; start = 1'b0;
    wait_done(nb, seen, held);
    exp = exp_q.pop_front();
    checks++; if (!seen || result !== exp[31:0] || led_cout !== exp[32]) begin
      errors++; $display("FAIL b2b_snapshot: got seen=%b %b/%h expected %b/%h", seen, led_cout, result, exp[32], exp[31:0]); end
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      test_op("random", $urandom, $urandom, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_display();
    test_carry_chain();
    test_start_while_busy();
    test_reset_midcalc();
    test_count();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
